// File: rtl/aes_pkg.sv
`default_nettype none
//============================================================================
// aes_pkg - GF(2^8) helpers, MixColumns coefficients, state layout helper
// rev 1.0
//============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // First-row coefficients; row r uses this word rotated right by r bytes.
  localparam logic [31:0] MIX_FWD = 32'h02030101;
  localparam logic [31:0] MIX_INV = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Column 0 sits in the most significant word of the state.
  function automatic int col_lsb(input int nb, input int c);
    return 32 * (nb - 1 - c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_column_word.sv
`default_nettype none
//============================================================================
// mix_column_word - combinational (Inv)MixColumns on one 32-bit column
// rev 1.0
//============================================================================
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [31:0] coef;

  always_comb begin
    coef  = inv_i ? MIX_INV : MIX_FWD;
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_o[31-8*r -: 8] = col_o[31-8*r -: 8] ^
                             gf_mul(col_i[31-8*j -: 8], coef[31-8*((j-r+4)%4) -: 8]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
//============================================================================
// mix_columns_engine - iterative NB-column (Inv)MixColumns with valid/ready
// rev 1.0
//============================================================================
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data
);

  localparam int W  = 32 * NB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  // Modulo keeps the fully parallel case from truncating; the step is unused there.
  localparam logic [CW-1:0] CNT_STEP = CW'(COLS_PER_CYCLE % NB);

  mc_state_e     state_q;
  logic [CW-1:0] col_cnt_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_d;
  logic [W-1:0]  out_data_q;
  logic          inv_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          last_col;

  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col_in[k] = data_q[col_lsb(NB, int'(col_cnt_q) + k) +: 32];
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    mix_column_word u_mix (
      .col_i (col_in[k]),
      .inv_i (inv_q),
      .col_o (col_out[k])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      res_d[col_lsb(NB, int'(col_cnt_q) + k) +: 32] = col_out[k];
    end
    last_col = (int'(col_cnt_q) + COLS_PER_CYCLE) == NB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_cnt_q   <= '0;
      data_q      <= '0;
      res_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            inv_q      <= in_inv;
            col_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_q <= res_d;
          if (last_col) begin
            col_cnt_q   <= '0;
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            col_cnt_q <= col_cnt_q + CNT_STEP;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
//============================================================================
// tb_mix_columns_engine - directed + round-trip bench with a matrix model
// rev 1.0
//============================================================================
module tb_mix_columns_engine;

  localparam int LAT = 4;
  localparam logic [127:0] V1    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2    = 128'hd4bf5d30_db135345_f20a225c_01010101;
  localparam logic [127:0] V2OUT = 128'h046681e5_8e4da1bc_9fdc589d_01010101;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;

  logic         pv = 1'b0;
  logic         pinv = 1'b0;
  logic         pr = 1'b1;
  logic [127:0] pd4 = '0;
  logic [255:0] pd8 = '0;
  logic         p4_ir, p4_ov, p8_ir, p8_ov;
  logic [127:0] p4_od;
  logic [255:0] p8_od;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  mix_columns_engine #(.NB(4), .COLS_PER_CYCLE(4)) dut_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(pv), .in_ready(p4_ir),
    .in_data(pd4), .in_inv(pinv), .out_valid(p4_ov),
    .out_ready(pr), .out_data(p4_od)
  );

  mix_columns_engine #(.NB(8), .COLS_PER_CYCLE(2)) dut_p8 (
    .clk(clk), .rst_n(rst_n), .in_valid(pv), .in_ready(p8_ir),
    .in_data(pd8), .in_inv(pinv), .out_valid(p8_ov),
    .out_ready(pr), .out_data(p8_od)
  );

  // ---------------- reference model: plain matrix product over GF(2^8)
  logic [7:0] MF [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                            '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
  logic [7:0] MI [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                            '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] w, input logic inv);
    logic [7:0]  s [4];
    logic [7:0]  acc;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) s[j] = w[31-8*j -: 8];
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(inv ? MI[i][j] : MF[i][j], s[j]);
      r[31-8*i -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [255:0] model_blk(input logic [255:0] b, input int nb, input logic inv);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < nb; c++) r[32*(nb-c)-1 -: 32] = model_col(b[32*(nb-c)-1 -: 32], inv);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare process for the NB=4/CPC=1 engine
  typedef struct {
    logic [127:0] exp;
    int           acc;
  } item_t;

  item_t        q[$];
  logic [127:0] last_out = '0;
  logic [127:0] prev_data = '0;
  logic         prev_hold = 1'b0;

  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      q.delete();
      last_out  = '0;
      prev_hold = 1'b0;
    end else begin
      chk("in_ready", in_ready, q.size() == 0);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
        else if (!prev_hold) begin
          chk("latency", cyc - q[0].acc, LAT);
          chk("out_data", out_data, q[0].exp);
        end else chk("out_hold", out_data, prev_data);
      end else begin
        chk("idle_out_data", out_data, last_out);
        if (q.size() > 0 && (cyc - q[0].acc) > LAT) begin
          chk("out_valid_timeout", out_valid, 1'b1);
          void'(q.pop_front());
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        last_out = q[0].exp;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        it.exp = model_blk({128'h0, in_data}, 4, in_inv);
        it.acc = cyc + 1;
        q.push_back(it);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // ---------------- stimulus helpers (entered just after a rising edge)
  task automatic send(input logic [127:0] d, input logic inv, input int bound);
    bit ok;
    ok = 0;
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_out(output logic [127:0] d, input int bound);
    bit seen;
    seen = 0;
    d = '0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        d = out_data;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) chk("wait_out_timeout", 1'b0, 1'b1);
  endtask

  task automatic par_run(input logic [127:0] d, input logic inv, input logic [127:0] exp);
    bit g4, g8;
    int lat;
    g4 = 0; g8 = 0; lat = 0;
    pd4 = d; pd8 = {d, d}; pinv = inv; pv = 1'b1;
    @(negedge clk);
    chk("p4_in_ready", p4_ir, 1'b1);
    chk("p8_in_ready", p8_ir, 1'b1);
    @(posedge clk);
    #1;
    pv = 1'b0;
    pinv = ~inv;
    pd4 = ~d;
    pd8 = ~{d, d};
    for (int i = 0; i < 20 && !(g4 && g8); i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (p4_ov && !g4) begin
        g4 = 1;
        chk("p4_latency", lat, 1);
        chk("p4_data", p4_od, exp);
      end
      if (p8_ov && !g8) begin
        g8 = 1;
        chk("p8_latency", lat, 4);
        chk("p8_data", p8_od, {exp, exp});
      end
    end
    if (!g4) chk("p4_timeout", 1'b0, 1'b1);
    if (!g8) chk("p8_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence
  initial begin
    logic [127:0] t, u, r;

    chk("model_pin_c0", model_col(32'hdb135345, 1'b0), 32'h8e4da1bc);
    chk("model_pin_c1", model_col(32'hf20a225c, 1'b0), 32'h9fdc589d);
    chk("model_pin_d4", model_col(32'hd4bf5d30, 1'b0), 32'h046681e5);
    chk("model_pin_inv", model_col(32'h046681e5, 1'b1), 32'hd4bf5d30);
    chk("model_pin_c6", model_col(32'hc6c6c6c6, 1'b0), 32'hc6c6c6c6);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_p8_out_valid", p8_ov, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(V1, 1'b0, 20);
    wait_out(t, 20);
    chk("vec1_fwd", t, V1OUT);
    send(V1OUT, 1'b1, 20);
    wait_out(t, 20);
    chk("vec1_inv", t, V1);
    send(V2, 1'b0, 20);
    wait_out(t, 20);
    chk("vec2_fwd", t, V2OUT);
    send(V2OUT, 1'b1, 20);
    wait_out(t, 20);
    chk("vec2_inv", t, V2);

    par_run(V1, 1'b0, V1OUT);
    par_run(V1OUT, 1'b1, V1);

    // Backpressure with a second block waiting at the input.
    out_ready = 1'b0;
    send(V1, 1'b0, 20);
    wait_out(t, 20);
    fork
      send(V2, 1'b0, 100);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 1'b0);
          chk("bp_out_valid", out_valid, 1'b1);
          chk("bp_out_data", out_data, V1OUT);
        end
        out_ready = 1'b1;
      end
    join
    wait_out(t, 20);
    chk("bp_second_block", t, V2OUT);

    // Reset during BUSY.
    send(V2, 1'b1, 20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy_out_valid", out_valid, 1'b0);
    chk("rst_busy_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(V1, 1'b0, 20);
    wait_out(t, 20);
    chk("after_rst_busy", t, V1OUT);

    // Reset during DONE.
    out_ready = 1'b0;
    send(V2, 1'b0, 20);
    wait_out(t, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", out_valid, 1'b0);
    chk("rst_done_out_data", out_data, 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(V2OUT, 1'b1, 20);
    wait_out(t, 20);
    chk("after_rst_done", t, V2);

    // Inputs disturbed after accept must not matter.
    send(V1, 1'b0, 20);
    in_data = V2;
    in_inv  = 1'b1;
    wait_out(t, 20);
    chk("sample_at_accept", t, V1OUT);

    for (int n = 0; n < 500; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(r, 1'b0, 20);
      wait_out(t, 20);
      send(t, 1'b1, 20);
      wait_out(u, 20);
      chk("roundtrip", u, r);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
